// File: rtl/ws2812b_strip_driver.sv
// WS2812B strip driver: double-buffered pixel frame, brightness scaling,
// selectable colour order, bit serialiser with latch gap and busy/done handshake.

module ws2812b_px_scale (
  input  logic [7:0] comp,
  input  logic [7:0] brightness,
  output logic [7:0] scaled
);
  logic [15:0] prod;

  // 8x9-bit product; brightness+1 makes 255 an exact pass-through
  assign prod   = {8'd0, comp} * {7'd0, ({1'b0, brightness} + 9'd1)};
  assign scaled = 8'(prod >> 8);
endmodule

module ws2812b_strip_driver #(
  parameter int NB_LEDS     = 12,
  parameter int T0H         = 20,
  parameter int T1H         = 40,
  parameter int T_BIT       = 62,
  parameter int T_LATCH     = 3000,
  parameter int COLOR_ORDER = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       start,
  input  logic       auto_refresh,
  input  logic [7:0] brightness,
  output logic       busy,
  output logic       done,
  output logic       data_ws2812b
);
  localparam int CNT_MAX = (T_LATCH > T_BIT) ? T_LATCH : T_BIT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] BIT_LAST   = CW'(T_BIT - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(T_LATCH - 1);
  localparam logic [CW-1:0] HI0        = CW'(T0H);
  localparam logic [CW-1:0] HI1        = CW'(T1H);
  localparam logic [7:0]    LED_LAST   = 8'(NB_LEDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, LATCH = 2'd2} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [4:0]    bit_idx, bit_n;
  logic [7:0]    led, led_n, nxt_led;
  logic [23:0]   shift, shift_n;
  logic [23:0]   back  [NB_LEDS];
  logic [23:0]   front [NB_LEDS];
  logic [23:0]   acc   [NB_LEDS+1];
  logic [23:0]   front_nxt, src_pix, scaled_pix, word;
  logic          latch_last, begin_frame, data_n;

  assign nxt_led = led + 8'd1;
  assign acc[0]  = '0;

  // Per-pixel back-buffer write port and next-pixel read mux
  for (genvar i = 0; i < NB_LEDS; i++) begin : g_px
    assign acc[i+1] = acc[i] | ((nxt_led == 8'(i)) ? front[i] : 24'd0);
    always_ff @(posedge clk)
      if (reset)                              back[i] <= '0;
      else if (wr_en && (wr_addr == 8'(i)))   back[i] <= {red, green, blue};
  end
  assign front_nxt = acc[NB_LEDS];

  // Frame start reads pixel 0 straight from the back buffer (same word the copy takes)
  assign src_pix = (state == SEND) ? front_nxt : back[0];

  for (genvar c = 0; c < 3; c++) begin : g_comp
    ws2812b_px_scale u_scale (
      .comp       (src_pix[c*8 +: 8]),
      .brightness (brightness),
      .scaled     (scaled_pix[c*8 +: 8])
    );
  end

  // scaled_pix is {R',G',B'}
  assign word = (COLOR_ORDER == 1) ? scaled_pix
                                   : {scaled_pix[15:8], scaled_pix[23:16], scaled_pix[7:0]};

  assign latch_last  = (state == LATCH) && (cyc == LATCH_LAST);
  assign begin_frame = ((state == IDLE) && start) || (latch_last && (start || auto_refresh));
  assign busy        = (state != IDLE);
  assign done        = latch_last;

  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    bit_n   = bit_idx;
    led_n   = led;
    shift_n = shift;
    if (begin_frame) begin
      state_n = SEND;
      cyc_n   = '0;
      bit_n   = 5'd23;
      led_n   = '0;
      shift_n = word;
    end else begin
      case (state)
        SEND: begin
          if (cyc == BIT_LAST) begin
            cyc_n = '0;
            if (bit_idx != 5'd0) begin
              bit_n   = bit_idx - 5'd1;
              shift_n = {shift[22:0], 1'b0};
            end else if (led == LED_LAST) begin
              state_n = LATCH;
            end else begin
              led_n   = nxt_led;
              bit_n   = 5'd23;
              shift_n = word;
            end
          end else begin
            cyc_n = cyc + 1'b1;
          end
        end
        LATCH: begin
          if (latch_last) state_n = IDLE;
          else            cyc_n   = cyc + 1'b1;
        end
        default: ;
      endcase
    end
    // Output is registered, so derive it from the upcoming cycle's position
    data_n = (state_n == SEND) && (cyc_n < (shift_n[23] ? HI1 : HI0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cyc          <= '0;
      bit_idx      <= '0;
      led          <= '0;
      shift        <= '0;
      data_ws2812b <= 1'b0;
      front        <= '{default: '0};
    end else begin
      state        <= state_n;
      cyc          <= cyc_n;
      bit_idx      <= bit_n;
      led          <= led_n;
      shift        <= shift_n;
      data_ws2812b <= data_n;
      if (begin_frame) front <= back;
    end
  end
endmodule

// File: tb/tb_ws2812b_strip_driver.sv
// Bench for ws2812b_strip_driver: two instances (both colour orders) checked
// cycle-by-cycle against a pixel-level model of the expected waveform.

module tb_ws2812b_strip_driver;
  localparam int NB       = 8;
  localparam int T0H      = 2;
  localparam int T1H      = 4;
  localparam int T_BIT    = 6;
  localparam int T_LATCH  = 2500;
  localparam int SEND_CYC = NB * 24 * T_BIT;
  localparam int FRAME    = SEND_CYC + T_LATCH;

  logic       clk = 1'b0;
  logic       reset, wr_en, start, auto_refresh;
  logic [7:0] wr_addr, red, green, blue, brightness;
  logic       busy0, done0, data0, busy1, done1, data1;

  always #5 clk = ~clk;

  ws2812b_strip_driver #(.NB_LEDS(NB), .T0H(T0H), .T1H(T1H), .T_BIT(T_BIT),
                         .T_LATCH(T_LATCH), .COLOR_ORDER(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .red(red),
    .green(green), .blue(blue), .start(start), .auto_refresh(auto_refresh),
    .brightness(brightness), .busy(busy0), .done(done0), .data_ws2812b(data0));

  ws2812b_strip_driver #(.NB_LEDS(NB), .T0H(T0H), .T1H(T1H), .T_BIT(T_BIT),
                         .T_LATCH(T_LATCH), .COLOR_ORDER(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .red(red),
    .green(green), .blue(blue), .start(start), .auto_refresh(auto_refresh),
    .brightness(brightness), .busy(busy1), .done(done1), .data_ws2812b(data1));

  int checks = 0, failures = 0;
  logic [7:0]  mr [NB], mg [NB], mb [NB];
  logic [23:0] snap0 [NB], snap1 [NB], got0 [NB], got1 [NB];

  typedef struct {
    logic [7:0]  r, g, b, br;
    logic [23:0] w0, w1;
  } vec_t;
  vec_t vecs [7];

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%06h required=%06h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_word(input logic [7:0] r, g, b, br, input bit ord);
    int rs, gs, bs;
    rs = (int'(r) * (int'(br) + 1)) / 256;
    gs = (int'(g) * (int'(br) + 1)) / 256;
    bs = (int'(b) * (int'(br) + 1)) / 256;
    return ord ? {rs[7:0], gs[7:0], bs[7:0]} : {gs[7:0], rs[7:0], bs[7:0]};
  endfunction

  task automatic take_snapshot();
    for (int i = 0; i < NB; i++) begin
      snap0[i] = exp_word(mr[i], mg[i], mb[i], brightness, 1'b0);
      snap1[i] = exp_word(mr[i], mg[i], mb[i], brightness, 1'b1);
    end
  endtask

  // Drive a write for the coming edge and mirror it in the model
  task automatic model_write(input int addr, input logic [7:0] r, g, b);
    wr_en = 1'b1; wr_addr = 8'(addr); red = r; green = g; blue = b;
    if (addr < NB) begin mr[addr] = r; mg[addr] = g; mb[addr] = b; end
  endtask

  task automatic wr_px(input int addr, input logic [7:0] r, g, b);
    model_write(addr, r, g, b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) begin mr[i] = '0; mg[i] = '0; mb[i] = '0; end
  endtask

  // Walk one frame cycle by cycle; start must already be driven for edge N
  task automatic check_frame(input string tag, input bit auto_lvl, input bit noise, input int abort_at);
    int          bd0, bd1, bb, px, b, c, wa;
    logic [23:0] c0 [NB], c1 [NB];
    logic [23:0] t0, t1;
    logic        e0, e1;
    bd0 = 0; bd1 = 0; bb = 0;
    for (int i = 0; i < NB; i++) begin
      c0[i] = snap0[i]; c1[i] = snap1[i]; got0[i] = '0; got1[i] = '0;
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      e0 = 1'b0; e1 = 1'b0;
      if (k < SEND_CYC) begin
        px = k / (24 * T_BIT);
        b  = 23 - (k / T_BIT) % 24;
        c  = k % T_BIT;
        t0 = c0[px] >> b;
        t1 = c1[px] >> b;
        e0 = (c < (t0[0] ? T1H : T0H));
        e1 = (c < (t1[0] ? T1H : T0H));
        if (c == T0H) begin
          got0[px] = got0[px] | (24'(data0) << b);
          got1[px] = got1[px] | (24'(data1) << b);
        end
      end
      if (data0 !== e0) bd0++;
      if (data1 !== e1) bd1++;
      if (busy0 !== 1'b1 || busy1 !== 1'b1 ||
          done0 !== (k == FRAME - 1) || done1 !== (k == FRAME - 1)) bb++;
      if (k == abort_at) begin
        reset = 1'b1; start = 1'b0; wr_en = 1'b0;
        break;
      end
      auto_refresh = auto_lvl;
      start = noise && (k < FRAME - 1) && ($urandom_range(63) == 0);
      if (k == FRAME - 1) take_snapshot();
      wr_en = 1'b0;
      if (noise && $urandom_range(7) == 0) begin
        wa = $urandom_range(NB + 4);
        model_write(wa, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)));
      end
    end
    chk_i({tag, "_data_order0_bad_cycles"}, bd0, 0);
    chk_i({tag, "_data_order1_bad_cycles"}, bd1, 0);
    chk_i({tag, "_busy_done_bad_cycles"}, bb, 0);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk_b({tag, "_busy0"}, busy0, 1'b0);
    chk_b({tag, "_busy1"}, busy1, 1'b0);
    chk_b({tag, "_data0"}, data0, 1'b0);
    chk_b({tag, "_data1"}, data1, 1'b0);
    start = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; auto_refresh = 1'b0;
    wr_addr = '0; red = '0; green = '0; blue = '0; brightness = 8'd255;
    clear_model();

    vecs[0] = '{8'h00, 8'hFF, 8'h00, 8'd255, 24'hFF0000, 24'h00FF00};
    vecs[1] = '{8'hA5, 8'h00, 8'h3C, 8'd255, 24'h00A53C, 24'hA5003C};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'd127, 24'h7F7F7F, 24'h7F7F7F};
    vecs[3] = '{8'hFF, 8'h80, 8'h01, 8'd0,   24'h000000, 24'h000000};
    vecs[4] = '{8'h80, 8'h80, 8'h80, 8'd255, 24'h808080, 24'h808080};
    vecs[5] = '{8'h12, 8'h34, 8'h56, 8'd128, 24'h1A092B, 24'h091A2B};
    vecs[6] = '{8'h01, 8'hFF, 8'hC8, 8'd200, 24'hC8009D, 24'h00C89D};

    @(negedge clk);
    chk_b("rst_busy", busy0, 1'b0);
    chk_b("rst_done", done0, 1'b0);
    chk_b("rst_data0", data0, 1'b0);
    chk_b("rst_data1", data1, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_check("after_rst");

    // Scaling and colour order vectors on pixel 0
    for (int v = 0; v < 7; v++) begin
      brightness = vecs[v].br;
      wr_px(0, vecs[v].r, vecs[v].g, vecs[v].b);
      take_snapshot();
      start = 1'b1;
      check_frame($sformatf("vec%0d", v), 1'b0, 1'b0, -1);
      chk_w($sformatf("vec%0d_word_order0", v), got0[0], vecs[v].w0);
      chk_w($sformatf("vec%0d_word_order1", v), got1[0], vecs[v].w1);
      idle_check($sformatf("vec%0d_end", v));
    end

    // Write on the frame-start edge belongs to the next frame
    brightness = 8'd255;
    wr_px(5, 8'h11, 8'h22, 8'h33);
    take_snapshot();
    start = 1'b1;
    model_write(5, 8'hAA, 8'hBB, 8'hCC);
    check_frame("same_edge", 1'b0, 1'b0, -1);
    chk_w("same_edge_old_px5", got0[5], 24'h221133);
    idle_check("same_edge_end");
    wr_px(NB, 8'h5A, 8'h5A, 8'h5A);
    wr_px(12, 8'hC3, 8'hC3, 8'hC3);
    take_snapshot();
    start = 1'b1;
    check_frame("next_frame", 1'b0, 1'b0, -1);
    chk_w("next_frame_px5_order0", got0[5], 24'hBBAACC);
    chk_w("next_frame_px5_order1", got1[5], 24'hAABBCC);
    idle_check("next_frame_end");

    // Auto refresh with random writes and ignored start pulses
    for (int i = 0; i < NB; i++)
      wr_px(i, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)));
    brightness = 8'($urandom_range(255));
    take_snapshot();
    start = 1'b1;
    auto_refresh = 1'b1;
    check_frame("auto1", 1'b1, 1'b1, -1);
    check_frame("auto2", 1'b1, 1'b1, -1);
    check_frame("auto3", 1'b1, 1'b1, -1);
    check_frame("auto4", 1'b0, 1'b1, -1);
    idle_check("auto_end");

    // Reset in the middle of pixel 3
    brightness = 8'd255;
    wr_px(3, 8'hFF, 8'hFF, 8'hFF);
    take_snapshot();
    start = 1'b1;
    check_frame("abort", 1'b0, 1'b0, 3 * 24 * T_BIT + 10 * T_BIT + 1);
    @(negedge clk);
    chk_b("abort_data0", data0, 1'b0);
    chk_b("abort_data1", data1, 1'b0);
    chk_b("abort_busy0", busy0, 1'b0);
    chk_b("abort_busy1", busy1, 1'b0);
    chk_b("abort_done0", done0, 1'b0);
    reset = 1'b0;
    clear_model();
    take_snapshot();
    start = 1'b1;
    check_frame("post_reset", 1'b0, 1'b0, -1);
    chk_w("post_reset_px3", got0[3], 24'h000000);
    idle_check("post_reset_end");

    // Random frames
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NB; i++)
        wr_px(i, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)));
      brightness = 8'($urandom_range(255));
      take_snapshot();
      start = 1'b1;
      check_frame($sformatf("rand%0d", f), 1'b0, 1'b1, -1);
      idle_check($sformatf("rand%0d_end", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ws2812b_strip_driver.md
# ws2812b_strip_driver

Parametrised WS2812B serial LED driver. It is the successor to the 12-LED ring controller and sits between the pattern logic and the strip data pin. The block holds a double-buffered frame of NB_LEDS pixels, applies a global brightness scale, and selects the wire colour order. It serialises frames on request or continuously, enforces the WS2812B latch (reset) gap, and reports progress through a busy/done handshake.

## Interface
Parameters:
- NB_LEDS, 12: number of pixels on the strip (1..255).
- T0H, 20: high time of a 0 bit, in clk cycles (0.4 µs at 50 MHz).
- T1H, 40: high time of a 1 bit, in clk cycles (0.8 µs).
- T_BIT, 62: total bit period in cycles (1.24 µs). Must be greater than T1H.
- T_LATCH, 3000: low time after the last bit, in cycles (60 µs). Must be at least 2500.
- COLOR_ORDER, 0: 0 sends G,R,B on the wire; 1 sends R,G,B.

Ports:
- clk, in, 1: 50 MHz system clock. Everything runs in this single clock domain.
- reset, in, 1: synchronous, active-high reset.
- wr_en, in, 1: writes {red, green, blue} to the back buffer at wr_addr.
- wr_addr, in, 8: pixel index. Writes with wr_addr ≥ NB_LEDS are ignored.
- red, in, 8: red component of the pixel being written.
- green, in, 8: green component of the pixel being written.
- blue, in, 8: blue component of the pixel being written.
- start, in, 1: level-sampled request to transmit one frame.
- auto_refresh, in, 1: when high, a new frame starts automatically after each latch gap.
- brightness, in, 8: global scale applied to every component (255 = full).
- busy, out, 1: high while a frame (bits plus latch gap) is in progress.
- done, out, 1: one-cycle pulse on the last cycle of the latch gap.
- data_ws2812b, out, 1: registered serial output to the strip.

## Operation
- **Buffers.** Back buffer and front buffer, each NB_LEDS × 24 bits.
  - Pixel writes go only to the back buffer and are accepted in any state.
  - When a frame begins, the whole back buffer is copied to the front buffer in one cycle.
  - A write on the same edge as the copy is not in that frame. It lands in the back buffer and appears in the next frame.
- **State machine.**
  - IDLE: data low, busy low.
    - A frame begins on start=1, or when auto_refresh=1 and the previous frame has just ended.
    - When a frame begins: copy back→front, led=0, bit=23, go to SEND.
  - SEND: serialise 24 bits per pixel, MSB first, for pixels 0 to NB_LEDS−1.
    - Per bit: data high for T1H cycles (bit=1) or T0H cycles (bit=0), then low for the rest of T_BIT.
    - After the last bit of the last pixel, go to LATCH.
  - LATCH: data low for T_LATCH cycles. On the final cycle, pulse done.
    - If auto_refresh=1 or start=1 in that cycle, start a new frame with no gap.
    - Otherwise go to IDLE.
- **Start handling.** start while busy is ignored; it is not queued.
- **Pixel word.** Each component c is scaled to (c × (brightness+1)) >> 8.
  - This is an 8×9-bit product; keep bits [15:8].
  - brightness=255 leaves c unchanged. brightness=0 gives 0 for every c < 256.
  - Wire word: {G',R',B'} when COLOR_ORDER=0, {R',G',B'} when COLOR_ORDER=1.
- **When inputs are sampled.** brightness and the pixel word are sampled into the shift register on the first cycle of each pixel's bit 23. A brightness change mid-frame therefore affects only the following pixels.
- **Reset.** Returns to IDLE and clears both buffers to 0. busy=0, done=0, data_ws2812b=0.
  - Reset mid-frame aborts the frame. data is low from the next edge.

## Timing
- **Output reset values:** busy=0, done=0, data_ws2812b=0.
- **Start latency.** start is sampled high at edge N. From edge N+1: busy=1 and data_ws2812b=1 (first bit high phase).
- **No gaps.** The next pixel's word is prefetched during the last bit of the current pixel. There are no idle cycles between bits or pixels; each bit lasts exactly T_BIT cycles.
- **Frame length.** busy stays high for exactly NB_LEDS×24×T_BIT + T_LATCH cycles. done is high in the last of these cycles.
- **Back-to-back frames.** With auto_refresh, busy stays continuously high across frames. done pulses once per frame, and the next high phase starts on the cycle after done.
- **Frame rate.** Defaults (NB_LEDS=12, T_BIT=62, T_LATCH=3000) give 20856 cycles per frame, i.e. 417.12 µs.

## Test plan
1. Reset, write pixel 0 = {r=0x00, g=0xFF, b=0x00}, other pixels 0, brightness=255, pulse start → first 8 bits have a 40-cycle high phase, then 280 bits with 20-cycle high phases. busy lasts 20856 cycles; done pulses once.
2. COLOR_ORDER=1, pixel 0 = {0xA5, 0x00, 0x3C} → wire bits are A5 00 3C, MSB first. Check each high phase is 40 or 20 cycles and each period is 62 cycles.
3. brightness=127, pixel value 0xFF → scaled 0x7F. brightness=0 → all bits 0. brightness=255, value 0x80 → 0x80.
4. Write to pixel 5 and pulse start on the same edge → the frame sends the old pixel 5. The next frame sends the new value. A write to wr_addr=12 changes nothing.
5. auto_refresh=1 for three frames → busy never drops, done pulses every 20856 cycles. Set auto_refresh=0 → IDLE after the current frame. A start pulse while busy has no effect.
6. Assert reset in the middle of pixel 3 → next edge: data=0, busy=0. A later start sends all-zero pixels.
